call_return_ctrl: RTL

- Next-PC sequencer sitting directly upstream of the 12-bit, 8-entry return-address stack.
- Owns the program counter and decodes a per-cycle control command (sequential, jump, call, return).
- Drives the stack's push_sig/pop_sig/tos_sig/push_data and consumes its out_data on return.
- Mirrors stack occupancy so overflow and underflow are caught before the stack is corrupted.

---
 rtl/call_return_ctrl_pkg.sv | 26 ++
 rtl/call_return_ctrl_if.sv | 36 +++
 rtl/ras_depth_counter.sv | 38 +++
 rtl/call_return_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/call_return_ctrl_pkg.sv
// Shared definitions for the next-PC sequencer and its return-address stack.
package call_return_ctrl_pkg;

  localparam int PC_W_DEF  = 12;
  localparam int DEPTH_DEF = 8;
  localparam int DEPTH_W   = 4;

  // Per-cycle control command encoding.
  typedef enum logic [1:0] {
    CMD_SEQ  = 2'b00,
    CMD_JUMP = 2'b01,
    CMD_CALL = 2'b10,
    CMD_RET  = 2'b11
  } cmd_e;

  // Sequencer states, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  // Sticky fault classification.
  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;

endpackage

// File: rtl/call_return_ctrl_if.sv
// Command and return-stack bundle between upstream, sequencer and stack.
interface call_return_ctrl_if
  import call_return_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) ();

  logic               cmd_valid;
  cmd_e               cmd;
  logic [PC_W-1:0]    target;
  logic               cmd_ready;
  logic [PC_W-1:0]    pc;
  logic               push_sig;
  logic [PC_W-1:0]    push_data;
  logic               pop_sig;
  logic               tos_sig;
  logic [PC_W-1:0]    tos_data;
  logic [DEPTH_W-1:0] depth;
  logic               fault;
  logic [1:0]         fault_code;

  // Upstream/stack side: issues commands and returns stack contents.
  modport master (
    output cmd_valid, cmd, target, tos_data,
    input  cmd_ready, pc, push_sig, push_data, pop_sig, tos_sig,
    input  depth, fault, fault_code
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd, target, tos_data,
    output cmd_ready, pc, push_sig, push_data, pop_sig, tos_sig,
    output depth, fault, fault_code
  );

endinterface

// File: rtl/ras_depth_counter.sv
// Mirror of return-stack occupancy, saturating at 0 and DEPTH.
module ras_depth_counter
  import call_return_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  logic [DEPTH_W-1:0] depth_r;

  // Count pushes and pops; simultaneous inc/dec cancel, limits never pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_r <= '0;
    end else if (inc && !dec && (depth_r != DEPTH_MAX)) begin
      depth_r <= depth_r + DEPTH_ONE;
    end else if (dec && !inc && (depth_r != '0)) begin
      depth_r <= depth_r - DEPTH_ONE;
    end else begin
      depth_r <= depth_r;
    end
  end

  assign depth = depth_r;
  assign full  = (depth_r == DEPTH_MAX);
  assign empty = (depth_r == '0);

endmodule

// File: rtl/call_return_ctrl.sv
// Next-PC sequencer driving an external return-address stack.
module call_return_ctrl
  import call_return_ctrl_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  call_return_ctrl_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

  logic [1:0]         state_r, state_nxt_s;
  logic [PC_W-1:0]    pc_r, pc_nxt_s, pc_plus1_s;
  logic               fault_r, fault_nxt_s;
  logic [1:0]         fault_code_r, fault_code_nxt_s;
  logic               push_s, pop_s, tos_s;
  logic               inc_s, dec_s, full_s, empty_s, accept_s;
  logic [DEPTH_W-1:0] depth_s;

  assign pc_plus1_s = pc_r + PC_ONE;
  assign accept_s   = bus.cmd_valid && (state_r == ST_RUN);

  ras_depth_counter #(.DEPTH(DEPTH)) u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_s),
    .dec   (dec_s),
    .depth (depth_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Decode state and accepted command into next PC, strobes and fault.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    fault_nxt_s      = fault_r;
    fault_code_nxt_s = fault_code_r;
    push_s           = 1'b0;
    pop_s            = 1'b0;
    tos_s            = 1'b0;
    inc_s            = 1'b0;
    dec_s            = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (accept_s) begin
          case (bus.cmd)
            CMD_SEQ:  pc_nxt_s = pc_plus1_s;
            CMD_JUMP: pc_nxt_s = bus.target;
            CMD_CALL: begin
              if (!full_s) begin
                push_s   = 1'b1;
                inc_s    = 1'b1;
                pc_nxt_s = bus.target;
              end else begin
                fault_nxt_s      = 1'b1;
                fault_code_nxt_s = FC_OVERFLOW;
                state_nxt_s      = ST_FAULT;
              end
            end
            CMD_RET: begin
              if (!empty_s) begin
                tos_s       = 1'b1;
                state_nxt_s = ST_RET_WAIT;
              end else begin
                fault_nxt_s      = 1'b1;
                fault_code_nxt_s = FC_UNDERFLOW;
                state_nxt_s      = ST_FAULT;
              end
            end
            default: pc_nxt_s = pc_r;
          endcase
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      ST_RET_WAIT: begin
        // Stack presents the return address this cycle; consume it.
        tos_s       = 1'b1;
        pop_s       = 1'b1;
        dec_s       = 1'b1;
        pc_nxt_s    = bus.tos_data;
        state_nxt_s = ST_RUN;
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        // Unreachable encoding: park safely rather than run on.
        fault_nxt_s = 1'b1;
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // Register architectural state; reset wins over any pending return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_RUN;
      pc_r         <= PC_RESET;
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      fault_r      <= fault_nxt_s;
      fault_code_r <= fault_code_nxt_s;
    end
  end

  assign bus.cmd_ready  = (state_r == ST_RUN);
  assign bus.pc         = pc_r;
  assign bus.push_sig   = push_s;
  assign bus.push_data  = push_s ? pc_plus1_s : '0;
  assign bus.pop_sig    = pop_s;
  assign bus.tos_sig    = tos_s;
  assign bus.depth      = depth_s;
  assign bus.fault      = fault_r;
  assign bus.fault_code = fault_code_r;

endmodule
